// File: rtl/fp_int2float_pkg.sv
// Shared definitions for the integer-to-float conversion pipeline.
//   exp_bias()    : exponent bias for a given exponent width, 2^(ew-1)-1
//   float_width() : width of a packed {sign, exponent, mantissa} float
//   rnd_mode_e    : encoding of the rnd_mode input
package fp_int2float_pkg;

  typedef enum logic {
    RND_NEAREST_EVEN = 1'b0,
    RND_TRUNCATE     = 1'b1
  } rnd_mode_e;

  function automatic int exp_bias(input int ewidth);
    return (1 << (ewidth - 1)) - 1;
  endfunction

  function automatic int float_width(input int ewidth, input int mwidth);
    return 1 + ewidth + mwidth;
  endfunction

endpackage

// File: rtl/find_first_one.sv
// Leading-one detector.
//   vec  : input vector
//   idx  : index of the highest set bit of vec (0 when vec is zero)
//   zero : 1 when no bit of vec is set
module find_first_one #(
  parameter int IWIDTH = 32
) (
  input  logic [IWIDTH-1:0]         vec,
  output logic [$clog2(IWIDTH)-1:0] idx,
  output logic                      zero
);

  localparam int IDXW = $clog2(IWIDTH);

  // Scanning upwards lets the last hit win, which is the highest set bit.
  always_comb begin
    idx  = '0;
    zero = 1'b1;
    for (int i = 0; i < IWIDTH; i++) begin
      if (vec[i]) begin
        idx  = IDXW'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_int2float_pipe.sv
// Three-stage integer to floating-point converter with power-of-two scaling.
// Result = src0 * 2^src1, packed as {sign, exp, man}.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake (src0, src1, is_signed, rnd_mode)
//   out_valid / out_ready : output handshake (out, inexact, overflow, underflow)
// Stages: S1 sign/magnitude + leading one, S2 normalise + round,
// S3 exponent, pack and flags. A single global stall freezes every stage
// whenever the output holds a result that downstream has not taken.
module fp_int2float_pipe
  import fp_int2float_pkg::*;
#(
  parameter int IWIDTH = 32,
  parameter int EWIDTH = 8,
  parameter int MWIDTH = 23,
  parameter int SCALEW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IWIDTH-1:0]        src0,
  input  logic [SCALEW-1:0]        src1,
  input  logic                     is_signed,
  input  logic                     rnd_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EWIDTH+MWIDTH:0]   out,
  output logic                     inexact,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int FW   = float_width(EWIDTH, MWIDTH);
  localparam int IDXW = $clog2(IWIDTH);
  localparam int EXW  = EWIDTH + SCALEW + 2;
  localparam int XW   = IWIDTH + MWIDTH + 2;
  localparam int BIAS = exp_bias(EWIDTH);
  localparam logic [EXW-1:0] MAX_EXP = EXW'((1 << EWIDTH) - 1);

  // Stage registers
  logic              s1_valid, s1_sign, s1_zero;
  logic [IWIDTH:0]   s1_mag;
  logic [IDXW-1:0]   s1_most;
  logic [SCALEW-1:0] s1_scale;
  rnd_mode_e         s1_rnd;

  logic              s2_valid, s2_sign, s2_zero, s2_carry, s2_inexact;
  logic [MWIDTH-1:0] s2_mant;
  logic [IDXW-1:0]   s2_most;
  logic [SCALEW-1:0] s2_scale;

  // S1 combinational signals
  logic              sign_c, zero_c;
  logic [IWIDTH:0]   wide_c, mag_c;
  logic [IDXW-1:0]   most_c;

  // S2 combinational signals
  logic [IDXW:0]     shamt_c;
  logic [IWIDTH-1:0] frac_c;
  logic [XW-1:0]     ext_c;
  logic [MWIDTH-1:0] mant_c;
  logic              guard_c, rbit_c, sticky_c, round_up_c;
  logic [MWIDTH:0]   sum_c;

  // S3 combinational signals
  logic [EXW-1:0]    exp_c;
  logic [FW-1:0]     res_c;
  logic              inexact_c, overflow_c, underflow_c;

  assign in_ready = !out_valid || out_ready;

  // Magnitude is formed one bit wider than the operand so that the most
  // negative two's-complement value negates without wrapping.
  always_comb begin
    sign_c = is_signed & src0[IWIDTH-1];
    wide_c = {sign_c, src0};
    mag_c  = sign_c ? -wide_c : wide_c;
  end

  // The magnitude never exceeds 2^IWIDTH-1, so the low IWIDTH bits suffice
  // for leading-one detection.
  find_first_one #(
    .IWIDTH(IWIDTH)
  ) u_find_first_one (
    .vec  (mag_c[IWIDTH-1:0]),
    .idx  (most_c),
    .zero (zero_c)
  );

  // Shifting by IWIDTH-most pushes the leading one out of the IWIDTH-bit
  // window, leaving only the fraction bits left-aligned. Two zero bits plus
  // the mantissa width are appended so guard/round/sticky always exist.
  always_comb begin
    shamt_c    = (IDXW+1)'(IWIDTH) - {1'b0, s1_most};
    frac_c     = IWIDTH'(s1_mag << shamt_c);
    ext_c      = {frac_c, {(MWIDTH+2){1'b0}}};
    mant_c     = ext_c[XW-1 -: MWIDTH];
    guard_c    = ext_c[XW-1-MWIDTH];
    rbit_c     = ext_c[XW-2-MWIDTH];
    sticky_c   = |ext_c[XW-3-MWIDTH:0];
    round_up_c = (s1_rnd == RND_NEAREST_EVEN) && guard_c &&
                 (rbit_c || sticky_c || mant_c[0]);
    sum_c      = {1'b0, mant_c} + {{MWIDTH{1'b0}}, round_up_c};
  end

  // Exponent sum is done wide enough that neither a large positive scale
  // nor a large negative one can wrap before the range checks.
  always_comb begin
    exp_c = EXW'(BIAS)
          + {{(EXW-IDXW){1'b0}}, s2_most}
          + {{(EXW-SCALEW){s2_scale[SCALEW-1]}}, s2_scale}
          + {{(EXW-1){1'b0}}, s2_carry};
    res_c       = '0;
    inexact_c   = 1'b0;
    overflow_c  = 1'b0;
    underflow_c = 1'b0;
    if (s2_zero) begin
      res_c = '0;
    end else if (!exp_c[EXW-1] && (exp_c >= MAX_EXP)) begin
      res_c      = {s2_sign, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
      overflow_c = 1'b1;
      inexact_c  = 1'b1;
    end else if (exp_c[EXW-1] || (exp_c == '0)) begin
      res_c       = {s2_sign, {(EWIDTH+MWIDTH){1'b0}}};
      underflow_c = 1'b1;
      inexact_c   = 1'b1;
    end else begin
      res_c     = {s2_sign, exp_c[EWIDTH-1:0], s2_mant};
      inexact_c = s2_inexact;
    end
  end

  // All stages move together only when the output slot can accept, which
  // keeps out and the flags frozen while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out        <= '0;
      inexact    <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (in_ready) begin
      s1_valid   <= in_valid;
      s1_sign    <= sign_c;
      s1_mag     <= mag_c;
      s1_most    <= most_c;
      s1_zero    <= zero_c;
      s1_scale   <= src1;
      s1_rnd     <= rnd_mode_e'(rnd_mode);

      s2_valid   <= s1_valid;
      s2_sign    <= s1_sign;
      s2_zero    <= s1_zero;
      s2_most    <= s1_most;
      s2_scale   <= s1_scale;
      s2_carry   <= sum_c[MWIDTH];
      s2_mant    <= sum_c[MWIDTH] ? '0 : sum_c[MWIDTH-1:0];
      s2_inexact <= guard_c | rbit_c | sticky_c;

      out_valid  <= s2_valid;
      out        <= res_c;
      inexact    <= inexact_c;
      overflow   <= overflow_c;
      underflow  <= underflow_c;
    end
  end

endmodule

// File: tb/tb_fp_int2float_pipe.sv
// Self-checking bench for fp_int2float_pipe at default parameters.
// Directed conversions, reset behaviour and a randomised stream compared
// against an arithmetic reference model.
module tb_fp_int2float_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src0;
  logic [7:0]  src1;
  logic        is_signed;
  logic        rnd_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        inexact;
  logic        overflow;
  logic        underflow;

  int checks   = 0;
  int failures = 0;

  logic [34:0] exp_q[$];

  fp_int2float_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src0      (src0),
    .src1      (src1),
    .is_signed (is_signed),
    .rnd_mode  (rnd_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .inexact   (inexact),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Reference: value = a * 2^b rounded to 24 significant bits, evaluated with
  // remainder-versus-half arithmetic. Returns {inexact, overflow, underflow, float}.
  function automatic logic [34:0] refConvert(input logic [31:0] a, input logic [7:0] b,
                                             input logic sgn, input logic trunc);
    logic [63:0] mag, kept, rem, half;
    int most, sh, e;
    logic neg, inx, up;
    if (a == 32'd0) return 35'd0;
    neg  = sgn & a[31];
    mag  = neg ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
    most = 0;
    while ((mag >> (most + 1)) != 64'd0) most++;
    inx = 1'b0;
    if (most <= 23) begin
      kept = mag << (23 - most);
    end else begin
      sh   = most - 23;
      kept = mag >> sh;
      rem  = mag - (kept << sh);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 64'd0);
      up   = !trunc && ((rem > half) || ((rem == half) && kept[0]));
      if (up) kept = kept + 64'd1;
    end
    e = 127 + most + int'($signed(b));
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      e++;
    end
    if (e >= 255) return {3'b110, neg, 8'hFF, 23'd0};
    if (e <= 0)   return {3'b101, neg, 31'd0};
    return {inx, 2'b00, neg, e[7:0], kept[22:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Sends one beat with out_ready held high, then waits (bounded) for the
  // result and checks value, flags and the three-cycle latency.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [7:0] b,
                               input logic sgn, input logic rnd,
                               input logic [31:0] exp_out, input logic [2:0] exp_flags);
    int cycles;
    @(negedge clk);
    src0      = a;
    src1      = b;
    is_signed = sgn;
    rnd_mode  = rnd;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    cycles   = 1;
    while (!out_valid && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_latency"}, cycles, 3);
    checkOutput({tag, "_out"}, out, exp_out);
    checkOutput({tag, "_flags"}, {inexact, overflow, underflow}, exp_flags);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent, received, cycles, stale, sel;
    logic pending;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    src0      = '0;
    src1      = '0;
    is_signed = 1'b1;
    rnd_mode  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out", {inexact, overflow, underflow, out}, 0);
    rst = 1'b0;

    $display("[TB] directed conversions");
    applyStimulus("one",       32'h0000_0001, 8'd0,   1'b1, 1'b0, 32'h3F80_0000, 3'b000);
    applyStimulus("minus_one", 32'hFFFF_FFFF, 8'd0,   1'b1, 1'b0, 32'hBF80_0000, 3'b000);
    applyStimulus("most_neg",  32'h8000_0000, 8'd0,   1'b1, 1'b0, 32'hCF00_0000, 3'b000);
    applyStimulus("tie_rne",   32'd16777217,  8'd0,   1'b1, 1'b0, 32'h4B80_0000, 3'b100);
    applyStimulus("tie_trunc", 32'd16777217,  8'd0,   1'b1, 1'b1, 32'h4B80_0000, 3'b100);
    applyStimulus("max_rne",   32'h7FFF_FFFF, 8'd0,   1'b1, 1'b0, 32'h4F00_0000, 3'b100);
    applyStimulus("max_trunc", 32'h7FFF_FFFF, 8'd0,   1'b1, 1'b1, 32'h4EFF_FFFF, 3'b100);
    applyStimulus("umax",      32'hFFFF_FFFF, 8'd0,   1'b0, 1'b0, 32'h4F80_0000, 3'b100);
    applyStimulus("half",      32'h0000_0001, 8'hFF,  1'b1, 1'b0, 32'h3F00_0000, 3'b000);
    applyStimulus("ovf",       32'h4000_0000, 8'd127, 1'b1, 1'b0, 32'h7F80_0000, 3'b110);
    applyStimulus("unf",       32'h0000_0001, 8'h80,  1'b1, 1'b0, 32'h0000_0000, 3'b101);
    applyStimulus("zero",      32'h0000_0000, 8'd5,   1'b1, 1'b1, 32'h0000_0000, 3'b000);

    $display("[TB] random stream");
    sent     = 0;
    received = 0;
    cycles   = 0;
    pending  = 1'b0;
    while ((sent < 100 || exp_q.size() != 0) && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      if (!pending && sent < 100 && $urandom_range(0, 9) < 7) begin
        sel = int'($urandom_range(0, 3));
        case (sel)
          0:       src0 = $urandom;
          1:       src0 = 32'($urandom_range(0, 255));
          2:       src0 = {8'd0, 24'($urandom)};
          default: begin
            case ($urandom_range(0, 3))
              0:       src0 = 32'h8000_0000;
              1:       src0 = 32'hFFFF_FFFF;
              2:       src0 = 32'h7FFF_FFFF;
              default: src0 = 32'h0000_0000;
            endcase
          end
        endcase
        if ($urandom_range(0, 4) == 0) src1 = 8'($urandom);
        else                           src1 = 8'($urandom_range(0, 40)) - 8'd20;
        is_signed = 1'($urandom);
        rnd_mode  = 1'($urandom);
        pending   = 1'b1;
      end
      in_valid  = pending;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("stream_spurious", out_valid, 0);
        end else begin
          checkOutput(out_ready ? "stream_out" : "stream_hold",
                      {inexact, overflow, underflow, out}, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            received++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(refConvert(src0, src1, is_signed, rnd_mode));
        pending = 1'b0;
        sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_count", received, 100);
    exp_q.delete();

    $display("[TB] reset with beats in flight");
    @(negedge clk);
    is_signed = 1'b1;
    rnd_mode  = 1'b0;
    src1      = 8'd0;
    for (int i = 0; i < 3; i++) begin
      src0     = 32'(i + 5);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out", {inexact, overflow, underflow, out}, 0);
    rst   = 1'b0;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("rst_stale", stale, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
